// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace-line emitter.
// ASCII symbols, FSM encoding and the hex digit mapping live here.
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CARET,
    S_TIME,
    S_AT,
    S_PC,
    S_COLON,
    S_SP1,
    S_KIND,
    S_ID,
    S_SP2,
    S_LT,
    S_EQ,
    S_SP3,
    S_DATA,
    S_HASH
  } state_t;

  localparam logic [7:0] A_CARET  = 8'h5e;
  localparam logic [7:0] A_AT     = 8'h40;
  localparam logic [7:0] A_COLON  = 8'h3a;
  localparam logic [7:0] A_SP     = 8'h20;
  localparam logic [7:0] A_DOLLAR = 8'h24;
  localparam logic [7:0] A_STAR   = 8'h2a;
  localparam logic [7:0] A_LT     = 8'h3c;
  localparam logic [7:0] A_EQ     = 8'h3d;
  localparam logic [7:0] A_HASH   = 8'h23;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  localparam int MAX_TIME = 9999;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n})
                       : (8'h57 + {4'h0, n});
  endfunction

endpackage

// File: rtl/cpu_trace_emitter_bin2bcd.sv
// Saturating binary time stamp to 4 BCD digits, plus the
// count of significant digits (at least one).
module trace_bin2bcd
  import cpu_trace_pkg::*;
#(
  parameter int TIME_W = 14
) (
  input  logic [TIME_W-1:0] bin,
  output logic [15:0]       bcd,
  output logic [2:0]        ndig
);

  logic [13:0] sat;
  logic [15:0] acc;

  always_comb begin
    if (32'(bin) > 32'(MAX_TIME)) sat = 14'(MAX_TIME);
    else                          sat = 14'(bin);
  end

  always_comb begin
    acc = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (acc[d*4 +: 4] >= 4'd5)
          acc[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
      end
      acc = {acc[14:0], sat[i]};
    end
  end

  assign bcd = acc;

  always_comb begin
    if (acc[15:12] != 4'd0)     ndig = 3'd4;
    else if (acc[11:8] != 4'd0) ndig = 3'd3;
    else if (acc[7:4] != 4'd0)  ndig = 3'd2;
    else                        ndig = 3'd1;
  end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises one retire record into an ASCII trace line,
// one character per valid/ready handshake.
module cpu_trace_emitter
  import cpu_trace_pkg::*;
#(
  parameter int TIME_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_kind,
  input  logic [TIME_W-1:0] in_time,
  input  logic [31:0]       in_pc,
  input  logic [4:0]        in_grf,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_data,
  output logic [7:0]        char,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              line_done,
  output logic              busy
);

  state_t            state, nxt;
  logic [2:0]        cnt, nxt_cnt;
  logic [7:0]        nxt_char;
  logic              kind_q;
  logic [TIME_W-1:0] time_q;
  logic [31:0]       pc_q, addr_q, data_q;
  logic [4:0]        grf_q;
  logic [15:0]       bcd;
  logic [2:0]        ndig;
  logic [3:0]        g_tens, g_ones;
  logic              adv, last;

  trace_bin2bcd #(.TIME_W(TIME_W)) u_bcd (
    .bin  (time_q),
    .bcd  (bcd),
    .ndig (ndig)
  );

  assign g_tens   = 4'(grf_q / 5'd10);
  assign g_ones   = 4'(grf_q % 5'd10);
  assign adv      = char_valid && char_ready;
  assign last     = (cnt == 3'd0);
  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    unique case (state)
      S_IDLE:  if (in_valid) nxt = S_CARET;
      S_CARET: if (adv) begin
        nxt     = S_TIME;
        nxt_cnt = ndig - 3'd1;
      end
      S_TIME:  if (adv) begin
        if (last) nxt = S_AT;
        else      nxt_cnt = cnt - 3'd1;
      end
      S_AT:    if (adv) begin
        nxt     = S_PC;
        nxt_cnt = 3'd7;
      end
      S_PC:    if (adv) begin
        if (last) nxt = S_COLON;
        else      nxt_cnt = cnt - 3'd1;
      end
      S_COLON: if (adv) nxt = S_SP1;
      S_SP1:   if (adv) nxt = S_KIND;
      S_KIND:  if (adv) begin
        nxt = S_ID;
        if (kind_q == KIND_MEM)  nxt_cnt = 3'd7;
        else if (grf_q >= 5'd10) nxt_cnt = 3'd1;
        else                     nxt_cnt = 3'd0;
      end
      S_ID:    if (adv) begin
        if (last) nxt = S_SP2;
        else      nxt_cnt = cnt - 3'd1;
      end
      S_SP2:   if (adv) nxt = S_LT;
      S_LT:    if (adv) nxt = S_EQ;
      S_EQ:    if (adv) nxt = S_SP3;
      S_SP3:   if (adv) begin
        nxt     = S_DATA;
        nxt_cnt = 3'd7;
      end
      S_DATA:  if (adv) begin
        if (last) nxt = S_HASH;
        else      nxt_cnt = cnt - 3'd1;
      end
      S_HASH:  if (adv) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Character for the upcoming state, so char is a plain register.
  always_comb begin
    nxt_char = 8'h00;
    unique case (nxt)
      S_CARET: nxt_char = A_CARET;
      S_TIME:  nxt_char = hex_ascii(bcd[{nxt_cnt[1:0], 2'b00} +: 4]);
      S_AT:    nxt_char = A_AT;
      S_PC:    nxt_char = hex_ascii(pc_q[{nxt_cnt, 2'b00} +: 4]);
      S_COLON: nxt_char = A_COLON;
      S_SP1:   nxt_char = A_SP;
      S_KIND:  nxt_char = (kind_q == KIND_MEM) ? A_STAR : A_DOLLAR;
      S_ID:    nxt_char = (kind_q == KIND_MEM)
                        ? hex_ascii(addr_q[{nxt_cnt, 2'b00} +: 4])
                        : hex_ascii(nxt_cnt[0] ? g_tens : g_ones);
      S_SP2:   nxt_char = A_SP;
      S_LT:    nxt_char = A_LT;
      S_EQ:    nxt_char = A_EQ;
      S_SP3:   nxt_char = A_SP;
      S_DATA:  nxt_char = hex_ascii(data_q[{nxt_cnt, 2'b00} +: 4]);
      S_HASH:  nxt_char = A_HASH;
      default: nxt_char = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      char       <= 8'h00;
      char_valid <= 1'b0;
      line_done  <= 1'b0;
      kind_q     <= 1'b0;
      time_q     <= '0;
      pc_q       <= '0;
      grf_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state      <= nxt;
      cnt        <= nxt_cnt;
      char       <= nxt_char;
      char_valid <= (nxt != S_IDLE);
      line_done  <= (state == S_HASH) && adv;
      if (state == S_IDLE && in_valid) begin
        kind_q <= in_kind;
        time_q <= in_time;
        pc_q   <= in_pc;
        grf_q  <= in_grf;
        addr_q <= in_addr;
        data_q <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Scoreboard bench for cpu_trace_emitter: expected lines are
// formatted with $sformatf and checked char by char by a monitor.
module tb_cpu_trace_emitter;

  localparam int TIME_W = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_kind;
  logic [TIME_W-1:0] in_time;
  logic [31:0]       in_pc;
  logic [4:0]        in_grf;
  logic [31:0]       in_addr;
  logic [31:0]       in_data;
  logic [7:0]        char;
  logic              char_valid;
  logic              char_ready;
  logic              line_done;
  logic              busy;

  cpu_trace_emitter #(.TIME_W(TIME_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_time    (in_time),
    .in_pc      (in_pc),
    .in_grf     (in_grf),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .char       (char),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .line_done  (line_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  bit         bp = 1'b0;
  int         cyc = 0;
  int         line_chars = 0;
  int         last_len = 0;
  int         last_hash_cyc = -100;
  int         last_gap = 0;
  int         lines = 0;
  bit         exp_ld = 1'b0;
  bit         prev_hold = 1'b0;
  bit         prev_valid = 1'b0;
  logic [7:0] prev_char = 8'h00;

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic string line_str(bit kind, int t, logic [31:0] pc,
                                     int grf, logic [31:0] addr,
                                     logic [31:0] data);
    int ts;
    ts = (t > 9999) ? 9999 : t;
    if (!kind)
      return $sformatf("^%0d@%08h: $%0d <= %08h#", ts, pc, grf, data);
    return $sformatf("^%0d@%08h: *%08h <= %08h#", ts, pc, addr, data);
  endfunction

  task automatic push_line(string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(bit kind, int t, logic [31:0] pc, int grf,
                      logic [31:0] addr, logic [31:0] data);
    int n;
    n = 0;
    in_kind  = kind;
    in_time  = TIME_W'(t);
    in_pc    = pc;
    in_grf   = 5'(grf);
    in_addr  = addr;
    in_data  = data;
    in_valid = 1'b1;
    push_line(line_str(kind, t, pc, grf, addr, data));
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 2000);
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stuck at 0");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) begin
      tests++;
      fails++;
      $display("FAIL line_timeout: %0d chars still pending", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    char_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      char_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
      exp_ld     = 1'b0;
      line_chars = 0;
    end else begin
      check("line_done", line_done, exp_ld);
      exp_ld = 1'b0;
      check("in_ready_vs_busy", in_ready, !busy);
      if (char_valid) check("in_ready_in_line", in_ready, 0);
      if (prev_hold) begin
        check("hold_valid", char_valid, 1);
        check("hold_char", char, prev_char);
      end
      if (char_valid && !prev_valid) last_gap = cyc - last_hash_cyc;
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_char: got %02h expected none", char);
        end else begin
          e = exp_q.pop_front();
          check("char", char, e);
        end
        line_chars++;
        if (char == 8'h23) begin
          exp_ld        = 1'b1;
          last_len      = line_chars;
          line_chars    = 0;
          last_hash_cyc = cyc;
          lines++;
        end
      end
      prev_hold  = char_valid && !char_ready;
      prev_valid = char_valid;
      prev_char  = char;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int l0, n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_kind  = 1'b0;
    in_time  = '0;
    in_pc    = '0;
    in_grf   = '0;
    in_addr  = '0;
    in_data  = '0;
    @(posedge clk);
    #1;
    check("rst_char_valid", char_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_char", char, 8'h00);
    check("rst_line_done", line_done, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    send(0, 5, 32'h00003000, 8, 32'h0, 32'h0000000a);
    wait_done();
    check("reg_len", last_len, 28);

    send(1, 1234, 32'h00003004, 0, 32'h0000ff04, 32'hdeadbeef);
    wait_done();
    check("mem_len", last_len, 38);

    send(0, 0, 32'h00000010, 31, 32'h0, 32'h12345678);
    wait_done();
    check("t0_len", last_len, 29);
    send(1, 12000, 32'habcdef01, 0, 32'h0badf00d, 32'h00000001);
    wait_done();
    send(0, 100, 32'h00000020, 10, 32'h0, 32'hffffffff);
    wait_done();

    bp = 1'b1;
    send(1, 1234, 32'h00003004, 0, 32'h0000ff04, 32'hdeadbeef);
    wait_done();
    check("bp_mem_len", last_len, 38);
    bp = 1'b0;

    send(1, 1234, 32'h00003004, 0, 32'h0000ff04, 32'hdeadbeef);
    n = 0;
    while (line_chars < 8 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_pc", line_chars >= 8, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_char_valid", char_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    reset = 1'b0;
    exp_q.delete();
    send(0, 42, 32'h00004000, 3, 32'h0, 32'hcafe0001);
    wait_done();
    check("post_rst_len", last_len, 29);

    l0 = lines;
    send(0, 7, 32'h00005000, 2, 32'h0, 32'h00000002);
    send(1, 9, 32'h00005004, 0, 32'h00001000, 32'h00000003);
    wait_done();
    check("b2b_lines", lines - l0, 2);
    check("b2b_gap", last_gap, 2);

    for (int k = 0; k < 20; k++) begin
      bp = $urandom_range(0, 1) != 0;
      send($urandom_range(0, 1) != 0, $urandom_range(0, 16383),
           $urandom, $urandom_range(0, 31), $urandom, $urandom);
      if ($urandom_range(0, 1) != 0) wait_done();
    end
    wait_done();
    bp = 1'b0;
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
